sfifo_unpack: RTL

- Read-side consumer for the synchronous FIFO: pops IW-bit words from an asynchronous-read FIFO read port and emits them as a stream of OW-bit sub-words over a valid/ready handshake.
- Sits between a wide-word FIFO (e.g. a bus-side buffer) and a narrow consumer such as a UART transmit path or a byte-serial engine.
- Zero-bubble: a new FIFO word is loaded in the same cycle the last sub-word of the current word is accepted.

---
 rtl/sfifo_unpack.sv | 72 +++++++
 1 files changed

// File: rtl/sfifo_unpack.sv
// Unpacks IW-bit words popped from an async-read FIFO into a stream of OW-bit sub-words.
// Define SFIFO_UNPACK_LAST_EN to add the o_last and o_count outputs.
module sfifo_unpack #(
    parameter int IW            = 32,
    parameter int OW            = 8,
    parameter bit OPT_LSB_FIRST = 1'b0,
    localparam int NW           = IW / OW,
    localparam int CW           = $clog2(NW) + 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    output logic          o_fifo_rd,
    input  logic [IW-1:0] i_fifo_data,
    input  logic          i_fifo_empty,
    input  logic          i_flush,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_busy
`ifdef SFIFO_UNPACK_LAST_EN
    ,
    output logic          o_last,
    output logic [CW-1:0] o_count
`endif
);

    logic [IW-1:0] sreg;
    logic [CW-1:0] nleft;
    logic          accept;
    logic          load;

    // Handshake: a sub-word transfers on a cycle where o_valid && i_ready; while
    // o_valid is high and i_ready low, o_valid and o_data hold unchanged.
    assign o_valid = (nleft != '0);
    assign accept  = o_valid && i_ready;

    // Reload as the last sub-word leaves so word boundaries cost no bubble cycle.
    assign load = i_reset_n && !i_fifo_empty && !i_flush &&
                  ((nleft == '0) || ((nleft == CW'(1)) && accept));

    assign o_fifo_rd = load;
    assign o_busy    = o_valid || !i_fifo_empty;

    generate
        if (OPT_LSB_FIRST) begin : g_lsb
            assign o_data = sreg[OW-1:0];
        end else begin : g_msb
            assign o_data = sreg[IW-1 -: OW];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sreg  <= '0;
            nleft <= '0;
        end else if (i_flush) begin
            nleft <= '0;
        end else if (load) begin
            sreg  <= i_fifo_data;
            nleft <= CW'(NW);
        end else if (accept) begin
            sreg  <= OPT_LSB_FIRST ? (sreg >> OW) : (sreg << OW);
            nleft <= nleft - CW'(1);
        end
    end

`ifdef SFIFO_UNPACK_LAST_EN
    assign o_last  = o_valid && (nleft == CW'(1));
    assign o_count = nleft;
`endif

endmodule
